// File: rtl/blackjack_pkg.sv
// Shared Blackjack types: deck index, dealer FSM states,
// default card geometry and rank encodings.
package blackjack_pkg;

  localparam int CARD_WIDTH_DEF  = 60;
  localparam int CARD_HEIGHT_DEF = 84;

  localparam logic [3:0] ACE   = 4'd1;
  localparam logic [3:0] JACK  = 4'd11;
  localparam logic [3:0] QUEEN = 4'd12;
  localparam logic [3:0] KING  = 4'd13;

  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    ACK
  } deal_state_t;

  function automatic logic [9:0] slot_left(
    input int x0,
    input int pitch,
    input int i
  );
    return 10'(x0 + i * pitch);
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
module card_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] value
);

  logic fb;

  assign fb = value[7] ^ value[5] ^ value[4] ^ value[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) value <= SEED;
    else          value <= {value[6:0], fb};
  end

endmodule

// File: rtl/card_dealer.sv
// Deck/hand manager with per-pixel slot lookup.
// CARD_DEALER_AUTOSHUFFLE_EN: refill an exhausted deck on request.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int         MAX_CARDS   = 6,
  parameter int         CARD_WIDTH  = CARD_WIDTH_DEF,
  parameter int         CARD_HEIGHT = CARD_HEIGHT_DEF,
  parameter int         CARD_GAP    = 8,
  parameter int         HAND_X0     = 40,
  parameter int         DEALER_Y    = 60,
  parameter int         PLAYER_Y    = 300,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       new_round,
  input  logic       deal_req,
  input  logic       deal_to,
  input  logic       deal_hidden,
  input  logic       reveal,
  output logic       deal_ack,
  output logic       deal_rej,
  output logic [3:0] deal_value,
  output logic       busy,
  output logic [2:0] player_count,
  output logic [2:0] dealer_count,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic [9:0] card_x,
  output logic [8:0] card_y,
  output logic [3:0] card_value,
  output logic       card_visible
);

  localparam int PITCH = CARD_WIDTH + CARD_GAP;

  deal_state_t state, state_n;
  card_idx_t   idx, first_idx, next_idx;

  logic [7:0]  lfsr;
  logic        lfsr_unused;
  logic [63:0] used;
  logic [5:0]  used_cnt;
  logic        tgt, hid;
  logic        load, adv, commit, rej, shuffle, full;
  logic [3:0]  val;

  logic [3:0]           p_rank [MAX_CARDS];
  logic [3:0]           d_rank [MAX_CARDS];
  logic [MAX_CARDS-1:0] p_hid, d_hid;

  card_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .value   (lfsr)
  );

  assign lfsr_unused = ^lfsr[7:6];
  assign deal_ack    = (state == ACK);
  assign busy        = (state != IDLE);
  assign val         = idx.rank + 4'd1;
  assign full = (deal_to ? dealer_count : player_count)
             == 3'(MAX_CARDS);

  always_comb begin
    first_idx.suit = lfsr[5:4];
    first_idx.rank = (lfsr[3:0] >= KING)
                   ? lfsr[3:0] - KING : lfsr[3:0];
    next_idx = idx;
    if (idx.rank == QUEEN) begin
      next_idx.rank = 4'd0;
      next_idx.suit = idx.suit + 2'd1;
    end else begin
      next_idx.rank = idx.rank + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    adv     = 1'b0;
    commit  = 1'b0;
    rej     = 1'b0;
    shuffle = 1'b0;
    if (new_round) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (deal_req) begin
          if (full) begin
            rej     = 1'b1;
            state_n = ACK;
          end else if (used_cnt == 6'd52) begin
`ifdef CARD_DEALER_AUTOSHUFFLE_EN
            shuffle = 1'b1;
            load    = 1'b1;
            state_n = PROBE;
`else
            rej     = 1'b1;
            state_n = ACK;
`endif
          end else begin
            load    = 1'b1;
            state_n = PROBE;
          end
        end
        PROBE: begin
          if (!used[idx]) begin
            commit  = 1'b1;
            state_n = ACK;
          end else begin
            adv = 1'b1;
          end
        end
        ACK:     state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx          <= '0;
      tgt          <= 1'b0;
      hid          <= 1'b0;
      used         <= '0;
      used_cnt     <= '0;
      player_count <= '0;
      dealer_count <= '0;
      p_rank       <= '{default: '0};
      d_rank       <= '{default: '0};
      p_hid        <= '0;
      d_hid        <= '0;
      deal_rej     <= 1'b0;
      deal_value   <= '0;
    end else begin
      deal_rej   <= rej;
      deal_value <= commit ? val : 4'd0;
      if (load) begin
        idx <= first_idx;
        tgt <= deal_to;
        hid <= deal_hidden;
      end else if (adv) begin
        idx <= next_idx;
      end
      if (shuffle) begin
        used     <= '0;
        used_cnt <= '0;
      end else if (commit) begin
        used[idx] <= 1'b1;
        used_cnt  <= used_cnt + 6'd1;
      end
      if (new_round) begin
        player_count <= '0;
        dealer_count <= '0;
      end else if (commit) begin
        if (tgt) begin
          d_rank[dealer_count] <= val;
          dealer_count <= dealer_count + 3'd1;
        end else begin
          p_rank[player_count] <= val;
          player_count <= player_count + 3'd1;
        end
      end
      // A reveal wins over a hidden card landing the same cycle.
      if (new_round || reveal) begin
        p_hid <= '0;
        d_hid <= '0;
      end else if (commit) begin
        if (tgt) d_hid[dealer_count] <= hid;
        else     p_hid[player_count] <= hid;
      end
    end
  end

  logic       hit, in_d, in_p;
  logic [9:0] hx;
  logic [8:0] hy;
  logic [3:0] hv;

  always_comb begin
    hit  = 1'b0;
    hx   = '0;
    hy   = '0;
    hv   = '0;
    in_d = (y >= 9'(DEALER_Y))
        && (y < 9'(DEALER_Y + CARD_HEIGHT));
    in_p = (y >= 9'(PLAYER_Y))
        && (y < 9'(PLAYER_Y + CARD_HEIGHT));
    for (int i = 0; i < MAX_CARDS; i++) begin
      if (x >= slot_left(HAND_X0, PITCH, i) &&
          x < slot_left(HAND_X0, PITCH, i)
              + 10'(CARD_WIDTH)) begin
        if (in_d && 3'(i) < dealer_count) begin
          hit = 1'b1;
          hx  = slot_left(HAND_X0, PITCH, i);
          hy  = 9'(DEALER_Y);
          hv  = d_hid[i] ? 4'd0 : d_rank[i];
        end else if (in_p && 3'(i) < player_count) begin
          hit = 1'b1;
          hx  = slot_left(HAND_X0, PITCH, i);
          hy  = 9'(PLAYER_Y);
          hv  = p_hid[i] ? 4'd0 : p_rank[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      card_x       <= '0;
      card_y       <= '0;
      card_value   <= '0;
      card_visible <= 1'b0;
    end else begin
      card_x       <= hx;
      card_y       <= hy;
      card_value   <= hv;
      card_visible <= hit;
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: deck/LFSR model predicts
// every deal; pixel lookup checked at slot boundaries.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_round = 1'b0;
  logic       deal_req = 1'b0;
  logic       deal_to = 1'b0;
  logic       deal_hidden = 1'b0;
  logic       reveal = 1'b0;
  logic       deal_ack, deal_rej, busy;
  logic [3:0] deal_value;
  logic [2:0] player_count, dealer_count;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic [9:0] card_x;
  logic [8:0] card_y;
  logic [3:0] card_value;
  logic       card_visible;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    bit         rej;
    logic [3:0] val;
    int         lat;
  } exp_t;

  exp_t sb[$];

  logic [7:0]  m_lfsr;
  logic [63:0] m_used;
  int          m_nused, m_pc, m_dc;
  logic [3:0]  m_pv [8];
  logic [3:0]  m_dv [8];
  int          tally [16];

  card_dealer dut (
    .clk          (clk),
    .reset_n      (rst_n),
    .new_round    (new_round),
    .deal_req     (deal_req),
    .deal_to      (deal_to),
    .deal_hidden  (deal_hidden),
    .reveal       (reveal),
    .deal_ack     (deal_ack),
    .deal_rej     (deal_rej),
    .deal_value   (deal_value),
    .busy         (busy),
    .player_count (player_count),
    .dealer_count (dealer_count),
    .x            (x),
    .y            (y),
    .card_x       (card_x),
    .card_y       (card_y),
    .card_value   (card_value),
    .card_visible (card_visible)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0],
                    m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic predict(input logic to, output exp_t e);
    int cnt, k;
    logic [1:0] s;
    logic [3:0] r;
    cnt   = to ? m_dc : m_pc;
    e.rej = 1'b1;
    e.val = 4'd0;
    e.lat = 1;
    if (cnt == 6) return;
    if (m_nused == 52) begin
`ifdef CARD_DEALER_AUTOSHUFFLE_EN
      m_used  = '0;
      m_nused = 0;
`else
      return;
`endif
    end
    s = m_lfsr[5:4];
    r = m_lfsr[3:0];
    if (r >= 4'd13) r = r - 4'd13;
    k = 1;
    while (m_used[{s, r}]) begin
      if (r == 4'd12) begin
        r = 4'd0;
        s = s + 2'd1;
      end else begin
        r = r + 4'd1;
      end
      k++;
    end
    m_used[{s, r}] = 1'b1;
    m_nused++;
    e.rej = 1'b0;
    e.val = r + 4'd1;
    e.lat = k + 1;
    if (to) begin
      m_dv[m_dc] = e.val;
      m_dc++;
    end else begin
      m_pv[m_pc] = e.val;
      m_pc++;
    end
  endtask

  task automatic deal(input logic to, input logic hidden);
    exp_t e;
    int n;
    @(negedge clk);
    predict(to, e);
    sb.push_back(e);
    deal_req    = 1'b1;
    deal_to     = to;
    deal_hidden = hidden;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      deal_req = 1'b0;
    end while (!deal_ack && n < 60);
    e = sb.pop_front();
    check("deal_ack", deal_ack, 1);
    if (deal_ack) begin
      check("deal_rej", deal_rej, e.rej);
      check("deal_value", deal_value, e.val);
      check("deal_latency", n, e.lat);
      check("player_count", player_count, m_pc);
      check("dealer_count", dealer_count, m_dc);
      if (!deal_rej) tally[deal_value]++;
    end
  endtask

  task automatic pulse_new_round();
    @(negedge clk);
    new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
    m_pc = 0;
    m_dc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    m_used  = '0;
    m_nused = 0;
    m_pc    = 0;
    m_dc    = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pix(input logic [9:0] px, input logic [8:0] py);
    @(negedge clk);
    x = px;
    y = py;
    @(negedge clk);
  endtask

  task automatic abort_deal(input logic to);
    @(negedge clk);
    deal_req    = 1'b1;
    deal_to     = to;
    deal_hidden = 1'b0;
    @(negedge clk);
    deal_req  = 1'b0;
    new_round = 1'b1;
    check("abort_in_probe", busy, 1);
    @(negedge clk);
    new_round = 1'b0;
    m_pc = 0;
    m_dc = 0;
    check("abort_ack", deal_ack, 0);
    check("abort_busy", busy, 0);
    check("abort_pcnt", player_count, 0);
    check("abort_dcnt", dealer_count, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_ack", deal_ack, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (tally[i]) tally[i] = 0;
    do_reset();
    @(negedge clk);
    check("rst_ack", deal_ack, 0);
    check("rst_rej", deal_rej, 0);
    check("rst_value", deal_value, 0);
    check("rst_busy", busy, 0);
    check("rst_pcnt", player_count, 0);
    check("rst_dcnt", dealer_count, 0);
    check("rst_card_x", card_x, 0);
    check("rst_card_y", card_y, 0);
    check("rst_card_value", card_value, 0);
    check("rst_visible", card_visible, 0);

    for (int i = 0; i < 52; i++) begin
      deal(1'(i % 2), 1'b0);
      if (i % 6 == 5) pulse_new_round();
    end
    for (int r = 1; r <= 13; r++)
      check($sformatf("rank%0d_x4", r), tally[r], 4);
    check("deck_empty_model", m_nused, 52);
    deal(1'b0, 1'b0);

    do_reset();
    deal(1'b1, 1'b1);
    pix(10'd45, 9'd65);
    check("hidden_visible", card_visible, 1);
    check("hidden_value", card_value, 0);
    check("hidden_card_x", card_x, 40);
    check("hidden_card_y", card_y, 60);
    @(negedge clk);
    reveal = 1'b1;
    @(negedge clk);
    reveal = 1'b0;
    @(negedge clk);
    check("reveal_value", card_value, m_dv[0]);

    deal(1'b0, 1'b0);
    deal(1'b0, 1'b0);
    pix(10'd177, 9'd305);
    check("empty_slot_vis", card_visible, 0);
    check("empty_slot_val", card_value, 0);
    pix(10'd108, 9'd305);
    check("slot1_card_x", card_x, 108);
    check("slot1_card_y", card_y, 300);
    check("slot1_visible", card_visible, 1);
    check("slot1_value", card_value, m_pv[1]);
    pix(10'd167, 9'd383);
    check("slot1_corner", card_value, m_pv[1]);
    pix(10'd168, 9'd305);
    check("slot1_right_edge", card_visible, 0);
    pix(10'd108, 9'd384);
    check("row_bottom_edge", card_visible, 0);
    pix(10'd39, 9'd305);
    check("slot0_left_edge", card_visible, 0);
    pix(10'd40, 9'd300);
    check("slot0_value", card_value, m_pv[0]);

    repeat (4) deal(1'b0, 1'b0);
    check("player_full", player_count, 6);
    deal(1'b0, 1'b0);
    deal(1'b1, 1'b0);

    abort_deal(1'b0);
    deal(1'b0, 1'b0);
    deal(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
